// File: rtl/id_ex_stage_if.sv
// Signal bundle between ID/hazard logic, the bypass buses and the ID/EX stage.
// The stage uses the slave view; the upstream driver uses the master view.
interface id_ex_stage_if #(
    parameter int N = 32
);
    logic         stall;
    logic         flush;
    logic         in_valid;
    logic [3:0]   in_alu_op;
    logic [N-1:0] in_rs_data;
    logic [N-1:0] in_rt_data;
    logic [N-1:0] in_imm;
    logic [4:0]   in_shamt;
    logic [4:0]   in_rs_addr;
    logic [4:0]   in_rt_addr;
    logic [4:0]   in_rd_addr;
    logic         in_use_imm;
    logic         in_reg_write;
    logic         exmem_reg_write;
    logic [4:0]   exmem_rd;
    logic [N-1:0] exmem_data;
    logic         memwb_reg_write;
    logic [4:0]   memwb_rd;
    logic [N-1:0] memwb_data;
    logic [3:0]   alu_op;
    logic [N-1:0] s;
    logic [N-1:0] t;
    logic [4:0]   shamt;
    logic [N-1:0] rt_fwd;
    logic [4:0]   rd_addr;
    logic         reg_write;
    logic         valid;

    modport master (
        output stall, flush, in_valid, in_alu_op, in_rs_data, in_rt_data, in_imm,
               in_shamt, in_rs_addr, in_rt_addr, in_rd_addr, in_use_imm, in_reg_write,
               exmem_reg_write, exmem_rd, exmem_data,
               memwb_reg_write, memwb_rd, memwb_data,
        input  alu_op, s, t, shamt, rt_fwd, rd_addr, reg_write, valid
    );

    modport slave (
        input  stall, flush, in_valid, in_alu_op, in_rs_data, in_rt_data, in_imm,
               in_shamt, in_rs_addr, in_rt_addr, in_rd_addr, in_use_imm, in_reg_write,
               exmem_reg_write, exmem_rd, exmem_data,
               memwb_reg_write, memwb_rd, memwb_data,
        output alu_op, s, t, shamt, rt_fwd, rd_addr, reg_write, valid
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX/MEM and MEM/WB operand bypass, stall hold
// (with operand refresh) and flush-to-bubble for the hazard unit.
module id_ex_stage #(
    parameter int N = 32
) (
    input  logic          clk,
    input  logic          reset,
    id_ex_stage_if.slave  bus
);
    localparam logic [3:0] OP_SLL = 4'h0;

    logic         valid_r;
    logic [3:0]   op_r;
    logic [N-1:0] rs_data_r;
    logic [N-1:0] rt_data_r;
    logic [N-1:0] imm_r;
    logic [4:0]   shamt_r;
    logic [4:0]   rs_addr_r;
    logic [4:0]   rt_addr_r;
    logic [4:0]   rd_addr_r;
    logic         use_imm_r;
    logic         reg_write_r;

    logic [N-1:0] rs_fwd_s;
    logic [N-1:0] rt_fwd_s;

    // EX/MEM wins over MEM/WB; register 0 never takes a bypassed value.
    function automatic logic [N-1:0] fwd_pick(
        input logic [4:0]   addr,
        input logic [N-1:0] stored,
        input logic         ex_we,
        input logic [4:0]   ex_rd,
        input logic [N-1:0] ex_data,
        input logic         wb_we,
        input logic [4:0]   wb_rd,
        input logic [N-1:0] wb_data
    );
        logic [N-1:0] res;
        if (ex_we && (ex_rd == addr) && (addr != 5'd0)) begin
            res = ex_data;
        end else if (wb_we && (wb_rd == addr) && (addr != 5'd0)) begin
            res = wb_data;
        end else begin
            res = stored;
        end
        return res;
    endfunction

    // Per-operand bypass selection, active only for a real instruction.
    always_comb begin
        rs_fwd_s = rs_data_r;
        rt_fwd_s = rt_data_r;
        if (valid_r) begin
            rs_fwd_s = fwd_pick(rs_addr_r, rs_data_r,
                                bus.exmem_reg_write, bus.exmem_rd, bus.exmem_data,
                                bus.memwb_reg_write, bus.memwb_rd, bus.memwb_data);
            rt_fwd_s = fwd_pick(rt_addr_r, rt_data_r,
                                bus.exmem_reg_write, bus.exmem_rd, bus.exmem_data,
                                bus.memwb_reg_write, bus.memwb_rd, bus.memwb_data);
        end else begin
            rs_fwd_s = rs_data_r;
            rt_fwd_s = rt_data_r;
        end
    end

    // Pipeline register: flush beats stall; a held stage refreshes its operands
    // so a bypassed value survives after the producer leaves the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_r     <= 1'b0;
            op_r        <= OP_SLL;
            rs_data_r   <= '0;
            rt_data_r   <= '0;
            imm_r       <= '0;
            shamt_r     <= 5'd0;
            rs_addr_r   <= 5'd0;
            rt_addr_r   <= 5'd0;
            rd_addr_r   <= 5'd0;
            use_imm_r   <= 1'b0;
            reg_write_r <= 1'b0;
        end else if (bus.flush) begin
            valid_r     <= 1'b0;
            op_r        <= OP_SLL;
            rs_data_r   <= '0;
            rt_data_r   <= '0;
            imm_r       <= '0;
            shamt_r     <= 5'd0;
            rs_addr_r   <= 5'd0;
            rt_addr_r   <= 5'd0;
            rd_addr_r   <= 5'd0;
            use_imm_r   <= 1'b0;
            reg_write_r <= 1'b0;
        end else if (bus.stall) begin
            rs_data_r   <= rs_fwd_s;
            rt_data_r   <= rt_fwd_s;
        end else begin
            valid_r     <= bus.in_valid;
            op_r        <= bus.in_alu_op;
            rs_data_r   <= bus.in_rs_data;
            rt_data_r   <= bus.in_rt_data;
            imm_r       <= bus.in_imm;
            shamt_r     <= bus.in_shamt;
            rs_addr_r   <= bus.in_rs_addr;
            rt_addr_r   <= bus.in_rt_addr;
            rd_addr_r   <= bus.in_rd_addr;
            use_imm_r   <= bus.in_use_imm;
            reg_write_r <= bus.in_reg_write;
        end
    end

    assign bus.valid     = valid_r;
    assign bus.alu_op    = op_r;
    assign bus.shamt     = shamt_r;
    assign bus.rd_addr   = rd_addr_r;
    assign bus.reg_write = reg_write_r & valid_r;
    assign bus.s         = rs_fwd_s;
    assign bus.t         = use_imm_r ? imm_r : rt_fwd_s;
    assign bus.rt_fwd    = rt_fwd_s;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: load, bypass priority, $0, immediate,
// stall refresh, flush+stall and asynchronous reset.
module tb_id_ex_stage;
    localparam int N = 32;
    localparam logic [3:0] OP_SLL = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h2;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    id_ex_stage_if #(.N(N)) bus ();

    id_ex_stage #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_bypass();
        bus.exmem_reg_write = 1'b0;
        bus.exmem_rd        = 5'd0;
        bus.exmem_data      = 32'h0;
        bus.memwb_reg_write = 1'b0;
        bus.memwb_rd        = 5'd0;
        bus.memwb_data      = 32'h0;
    endtask

    task automatic set_instr(input logic v, input logic [3:0] op, input logic [4:0] rs,
                             input logic [31:0] rsd, input logic [4:0] rt, input logic [31:0] rtd,
                             input logic [4:0] rd, input logic ui, input logic [31:0] imm,
                             input logic [4:0] sh, input logic rw);
        bus.in_valid     = v;
        bus.in_alu_op    = op;
        bus.in_rs_addr   = rs;
        bus.in_rs_data   = rsd;
        bus.in_rt_addr   = rt;
        bus.in_rt_data   = rtd;
        bus.in_rd_addr   = rd;
        bus.in_use_imm   = ui;
        bus.in_imm       = imm;
        bus.in_shamt     = sh;
        bus.in_reg_write = rw;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        clear_bypass();
        set_instr(1'b0, 4'h0, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd0, 1'b0);
        tick();

        // reset state
        check_val("rst_valid", 32'(bus.valid), 32'h0);
        check_val("rst_regw", 32'(bus.reg_write), 32'h0);
        check_val("rst_op", 32'(bus.alu_op), 32'(OP_SLL));
        check_val("rst_s", bus.s, 32'h0);
        check_val("rst_t", bus.t, 32'h0);
        check_val("rst_rtfwd", bus.rt_fwd, 32'h0);
        check_val("rst_shamt", 32'(bus.shamt), 32'h0);
        check_val("rst_rd", 32'(bus.rd_addr), 32'h0);

        // ADD $4,$2,$3 with $2=5, $3=7
        reset = 1'b0;
        set_instr(1'b1, OP_ADD, 5'd2, 32'd5, 5'd3, 32'd7, 5'd4, 1'b0, 32'h0, 5'd3, 1'b1);
        tick();
        check_val("add_valid", 32'(bus.valid), 32'h1);
        check_val("add_op", 32'(bus.alu_op), 32'(OP_ADD));
        check_val("add_s", bus.s, 32'd5);
        check_val("add_t", bus.t, 32'd7);
        check_val("add_rd", 32'(bus.rd_addr), 32'd4);
        check_val("add_regw", 32'(bus.reg_write), 32'h1);
        check_val("add_shamt", 32'(bus.shamt), 32'd3);

        // bypass priority on rs
        bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd2; bus.exmem_data = 32'h11;
        bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd2; bus.memwb_data = 32'h22;
        #1;
        check_val("byp_exmem_s", bus.s, 32'h11);
        check_val("byp_t_untouched", bus.t, 32'd7);
        bus.exmem_reg_write = 1'b0;
        #1;
        check_val("byp_memwb_s", bus.s, 32'h22);
        clear_bypass();
        #1;
        check_val("byp_none_s", bus.s, 32'd5);

        // register 0 is never forwarded
        set_instr(1'b1, OP_ADD, 5'd0, 32'h0, 5'd0, 32'h0, 5'd6, 1'b0, 32'h0, 5'd0, 1'b1);
        tick();
        bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd0; bus.exmem_data = 32'hFF;
        bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd0; bus.memwb_data = 32'hEE;
        #1;
        check_val("r0_s", bus.s, 32'h0);
        check_val("r0_t", bus.t, 32'h0);
        clear_bypass();

        // invalid instruction: no forwarding, reg_write gated
        set_instr(1'b0, OP_ADD, 5'd2, 32'h55, 5'd3, 32'h66, 5'd7, 1'b0, 32'h0, 5'd0, 1'b1);
        tick();
        bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd2; bus.exmem_data = 32'h99;
        #1;
        check_val("inv_s", bus.s, 32'h55);
        check_val("inv_regw", 32'(bus.reg_write), 32'h0);
        clear_bypass();

        // immediate selects imm for t, rt_fwd still sees the bypass
        set_instr(1'b1, OP_ADD, 5'd2, 32'd5, 5'd3, 32'd7, 5'd4, 1'b1, 32'hFFFF_FFFC, 5'd0, 1'b1);
        tick();
        bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd3; bus.exmem_data = 32'd9;
        #1;
        check_val("imm_t", bus.t, 32'hFFFF_FFFC);
        check_val("imm_rtfwd", bus.rt_fwd, 32'd9);
        clear_bypass();

        // stall refresh: memwb hit on $3 during the first held cycle only
        set_instr(1'b1, OP_ADD, 5'd2, 32'd5, 5'd3, 32'd7, 5'd4, 1'b0, 32'h0, 5'd0, 1'b1);
        tick();
        bus.stall = 1'b1;
        bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd3; bus.memwb_data = 32'hAB;
        set_instr(1'b1, 4'h5, 5'd8, 32'h44, 5'd9, 32'h33, 5'd9, 1'b0, 32'h0, 5'd1, 1'b1);
        #1;
        check_val("stall_c1_t", bus.t, 32'hAB);
        tick();
        clear_bypass();
        #1;
        check_val("stall_c2_t", bus.t, 32'hAB);
        check_val("stall_c2_rd", 32'(bus.rd_addr), 32'd4);
        tick();
        check_val("stall_c3_t", bus.t, 32'hAB);
        check_val("stall_c3_s", bus.s, 32'd5);
        bus.stall = 1'b0;
        tick();
        check_val("release_t", bus.t, 32'h33);
        check_val("release_rd", 32'(bus.rd_addr), 32'd9);
        check_val("release_op", 32'(bus.alu_op), 32'h5);

        // flush together with stall and a valid input
        bus.flush = 1'b1;
        bus.stall = 1'b1;
        set_instr(1'b1, OP_ADD, 5'd2, 32'd5, 5'd3, 32'd7, 5'd4, 1'b0, 32'h0, 5'd2, 1'b1);
        tick();
        check_val("flush_valid", 32'(bus.valid), 32'h0);
        check_val("flush_regw", 32'(bus.reg_write), 32'h0);
        check_val("flush_op", 32'(bus.alu_op), 32'(OP_SLL));
        check_val("flush_s", bus.s, 32'h0);
        check_val("flush_rd", 32'(bus.rd_addr), 32'h0);
        bus.flush = 1'b0;
        bus.stall = 1'b0;

        // asynchronous reset between edges, then a normal load afterwards
        tick();
        check_val("preRst_valid", 32'(bus.valid), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check_val("arst_valid", 32'(bus.valid), 32'h0);
        check_val("arst_s", bus.s, 32'h0);
        check_val("arst_rd", 32'(bus.rd_addr), 32'h0);
        #1;
        reset = 1'b0;
        tick();
        check_val("postRst_valid", 32'(bus.valid), 32'h1);
        check_val("postRst_t", bus.t, 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
